// File: rtl/alu_input_loader_if.sv
// -----------------------------------------------------------------------------
// alu_input_loader_if
// Groups the board-facing signals of the ALU input loader: the switch bank,
// the two raw push buttons, and the registered operand/code/status outputs
// that feed the ALU and the debug LEDs.
//
// Signals:
//   i_sw        switch bank (operands and code taken from the low bits)
//   i_btn_load  raw load button, active-high, asynchronous to the clock
//   i_btn_clear raw clear button, active-high, asynchronous to the clock
//   o_a, o_b    registered operands A and B
//   o_code      registered operation code
//   o_valid     high once A, B and code have all been loaded
//   o_state     current loader state for LED debug
//
// Modports:
//   master  board / test side: drives switches and buttons, observes outputs
//   slave   loader side: samples switches and buttons, drives outputs
// -----------------------------------------------------------------------------
interface alu_input_loader_if #(
   parameter int SIZE_SW  = 8,
   parameter int SIZE_OP  = 4,
   parameter int SIZE_COD = 6
);

   logic [SIZE_SW-1:0]  i_sw;
   logic                i_btn_load;
   logic                i_btn_clear;
   logic [SIZE_OP-1:0]  o_a;
   logic [SIZE_OP-1:0]  o_b;
   logic [SIZE_COD-1:0] o_code;
   logic                o_valid;
   logic [1:0]          o_state;

   modport master (
      output i_sw,
      output i_btn_load,
      output i_btn_clear,
      input  o_a,
      input  o_b,
      input  o_code,
      input  o_valid,
      input  o_state
   );

   modport slave (
      input  i_sw,
      input  i_btn_load,
      input  i_btn_clear,
      output o_a,
      output o_b,
      output o_code,
      output o_valid,
      output o_state
   );

endinterface

// File: rtl/alu_input_loader.sv
// -----------------------------------------------------------------------------
// alu_input_loader
// Front-end stage for the TP1 ALU. Each press of the load button captures the
// next field from the switch bank (operand A, then operand B, then the
// operation code) into stable registers. A press of the clear button zeroes
// everything and restarts at operand A.
//
// Ports:
//   i_clk    single clock, all state updates on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      alu_input_loader_if.slave (switches, buttons, registered outputs)
//
// Parameters:
//   SIZE_SW          switch bank width, at least max(SIZE_OP, SIZE_COD)
//   SIZE_OP          operand width
//   SIZE_COD         operation code width
//   DEBOUNCE_CYCLES  stable cycles needed to accept a button change (>= 2)
//
// Build option:
//   ALU_LOADER_DEBOUNCE_EN  when defined, each button path gets a debounce
//                           counter between the synchronizer and the edge
//                           detector; otherwise the synchronizer output feeds
//                           the edge detector directly and DEBOUNCE_CYCLES is
//                           ignored.
// -----------------------------------------------------------------------------
module alu_input_loader #(
   parameter int SIZE_SW         = 8,
   parameter int SIZE_OP         = 4,
   parameter int SIZE_COD        = 6,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   alu_input_loader_if.slave bus
);

   localparam int NBTN      = 2;
   localparam int BTN_LOAD  = 0;
   localparam int BTN_CLEAR = 1;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // --------------------------------------------------------------------------
   // Button front end
   // --------------------------------------------------------------------------
   logic [NBTN-1:0] btnRaw;
   logic [NBTN-1:0] syncMeta_q;
   logic [NBTN-1:0] syncLevel_q;
   logic [1:0]      syncValid_q;
   logic [NBTN-1:0] level;
   logic [NBTN-1:0] levelPrev_q;
   logic [NBTN-1:0] armed_q;
   logic [NBTN-1:0] btnPulse;

   assign btnRaw = {bus.i_btn_clear, bus.i_btn_load};

   // Two-flop synchronizer for both buttons. syncValid_q tracks when the
   // synchronizer pipeline holds real post-reset samples rather than the
   // reset zeros, so that the arming logic below can trust syncLevel_q.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         syncMeta_q  <= '0;
         syncLevel_q <= '0;
         syncValid_q <= '0;
      end else begin
         syncMeta_q  <= btnRaw;
         syncLevel_q <= syncMeta_q;
         syncValid_q <= {syncValid_q[0], 1'b1};
      end
   end

`ifdef ALU_LOADER_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [NBTN-1:0][CNT_W-1:0] dbCnt_q;
   logic [NBTN-1:0][CNT_W-1:0] dbCnt_d;
   logic [NBTN-1:0]            accLevel_q;
   logic [NBTN-1:0]            accLevel_d;

   // Debounce: count consecutive edges where the synchronized level disagrees
   // with the accepted level; any agreement restarts the count. The accepted
   // level flips on the edge where the count has already reached
   // DEBOUNCE_CYCLES-1, so a clean change needs DEBOUNCE_CYCLES disagreeing
   // edges before it is seen downstream.
   always_comb begin
      dbCnt_d    = '0;
      accLevel_d = accLevel_q;
      for (int i = 0; i < NBTN; i++) begin
         if (syncLevel_q[i] != accLevel_q[i]) begin
            if (dbCnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               accLevel_d[i] = syncLevel_q[i];
            end else begin
               dbCnt_d[i] = dbCnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce counter and accepted level registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dbCnt_q    <= '0;
         accLevel_q <= '0;
      end else begin
         dbCnt_q    <= dbCnt_d;
         accLevel_q <= accLevel_d;
      end
   end

   assign level = accLevel_q;
`else
   localparam int unusedDebounceCycles = DEBOUNCE_CYCLES;

   assign level = syncLevel_q;
`endif

   // Rising-edge detector plus arming. A button only becomes armed once its
   // synchronized level has been seen low after reset, so a button that is
   // already held while reset is released cannot generate a pulse until it
   // has been released and pressed again.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         levelPrev_q <= '0;
         armed_q     <= '0;
      end else begin
         levelPrev_q <= level;
         armed_q     <= armed_q | ({NBTN{syncValid_q[1]}} & ~syncLevel_q);
      end
   end

   assign btnPulse = level & ~levelPrev_q & armed_q;

   // --------------------------------------------------------------------------
   // Loader FSM and output registers
   // --------------------------------------------------------------------------
   logic                loadP;
   logic                clearP;
   state_t              state_q;
   state_t              state_d;
   logic [SIZE_OP-1:0]  a_q;
   logic [SIZE_OP-1:0]  a_d;
   logic [SIZE_OP-1:0]  b_q;
   logic [SIZE_OP-1:0]  b_d;
   logic [SIZE_COD-1:0] code_q;
   logic [SIZE_COD-1:0] code_d;
   logic                valid_q;
   logic                valid_d;

   assign loadP  = btnPulse[BTN_LOAD];
   assign clearP = btnPulse[BTN_CLEAR];

   // Next-state and register update logic. Clear has priority over load and
   // discards a coincident load. Reloading from S_DONE only replaces A; B and
   // the code keep their previous values until they are loaded again.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      code_d  = code_q;
      valid_d = valid_q;
      if (clearP) begin
         state_d = S_A;
         a_d     = '0;
         b_d     = '0;
         code_d  = '0;
         valid_d = 1'b0;
      end else if (loadP) begin
         case (state_q)
            S_A, S_DONE: begin
               a_d     = bus.i_sw[SIZE_OP-1:0];
               valid_d = 1'b0;
               state_d = S_B;
            end
            S_B: begin
               b_d     = bus.i_sw[SIZE_OP-1:0];
               state_d = S_OP;
            end
            S_OP: begin
               code_d  = bus.i_sw[SIZE_COD-1:0];
               valid_d = 1'b1;
               state_d = S_DONE;
            end
            default: begin
               state_d = S_A;
            end
         endcase
      end
   end

   // State and output registers; everything the ALU sees comes from here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_a     = a_q;
   assign bus.o_b     = b_q;
   assign bus.o_code  = code_q;
   assign bus.o_valid = valid_q;
   assign bus.o_state = state_q;

   // Switch bits above the widest field are intentionally not used.
   generate
      if (SIZE_SW > SIZE_COD) begin : g_unusedSw
         logic unusedSwBits;
         assign unusedSwBits = ^bus.i_sw[SIZE_SW-1:SIZE_COD];
      end
   endgenerate

endmodule

// File: tb/tb_alu_input_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_input_loader
// Directed plus randomized bench for alu_input_loader. Expected outputs come
// from a small model that counts loads since the last clear/reset and derives
// which field each load fills, the valid flag and the state from that count.
// -----------------------------------------------------------------------------
module tb_alu_input_loader;

`ifdef ALU_LOADER_DEBOUNCE_EN
   localparam int LAT = 2 + 16;
`else
   localparam int LAT = 2;
`endif
   localparam int HOLD = 40;
   localparam int GAP  = 40;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // Reference model state
   int         loadsSinceClear;
   logic [3:0] expA;
   logic [3:0] expB;
   logic [5:0] expCode;
   logic       expValid;
   logic [1:0] expState;

   alu_input_loader_if #(.SIZE_SW(8), .SIZE_OP(4), .SIZE_COD(6)) bus ();

   alu_input_loader #(
      .SIZE_SW(8),
      .SIZE_OP(4),
      .SIZE_COD(6),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the n-th load after a clear fills A, B, code in rotation.
   task automatic modelLoad(input logic [7:0] sw);
      int slot;
      loadsSinceClear++;
      slot = (loadsSinceClear - 1) % 3;
      if (slot == 0) begin
         expA     = sw[3:0];
         expValid = 1'b0;
      end else if (slot == 1) begin
         expB = sw[3:0];
      end else begin
         expCode  = sw[5:0];
         expValid = 1'b1;
      end
      expState = 2'(slot + 1);
   endtask

   task automatic modelClear();
      loadsSinceClear = 0;
      expA     = '0;
      expB     = '0;
      expCode  = '0;
      expValid = 1'b0;
      expState = 2'd0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".a"},     32'(bus.o_a),     32'(expA));
      checkOutput({tag, ".b"},     32'(bus.o_b),     32'(expB));
      checkOutput({tag, ".code"},  32'(bus.o_code),  32'(expCode));
      checkOutput({tag, ".valid"}, 32'(bus.o_valid), 32'(expValid));
      checkOutput({tag, ".state"}, 32'(bus.o_state), 32'(expState));
   endtask

   // Press the selected buttons for holdCycles, release, then wait GAP cycles.
   task automatic applyStimulus(input logic [7:0] sw, input bit doLoad,
                                input bit doClear, input int holdCycles);
      @(negedge clk);
      bus.i_sw        = sw;
      bus.i_btn_load  = doLoad;
      bus.i_btn_clear = doClear;
      repeat (holdCycles) @(negedge clk);
      bus.i_btn_load  = 1'b0;
      bus.i_btn_clear = 1'b0;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic pressLoad(input logic [7:0] sw);
      applyStimulus(sw, 1'b1, 1'b0, HOLD);
      modelLoad(sw);
   endtask

   task automatic pressClear();
      applyStimulus(8'h00, 1'b0, 1'b1, HOLD);
      modelClear();
   endtask

   initial begin
      int stateChanges;
      logic [1:0] prevState;
      logic [7:0] sw;
      int r;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_sw        = '0;
      bus.i_btn_load  = 1'b0;
      bus.i_btn_clear = 1'b0;
      modelClear();

      // Reset state
      repeat (3) @(negedge clk);
      checkAll("reset");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Basic A/B/code sequence
      pressLoad(8'h05);
      pressLoad(8'h0E);
      pressLoad(8'h20);
      checkAll("seq");

      // Clear from S_DONE
      pressClear();
      checkAll("clear");

      // Load latency: output must change exactly LAT edges after first sample
      @(negedge clk);
      bus.i_sw       = 8'h0A;
      bus.i_btn_load = 1'b1;
      @(posedge clk);
      repeat (LAT - 1) @(posedge clk);
      #1;
      checkOutput("lat.before", 32'(bus.o_a), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("lat.at", 32'(bus.o_a), 32'hA);
      repeat (HOLD) @(negedge clk);
      bus.i_btn_load = 1'b0;
      repeat (GAP) @(negedge clk);
      modelLoad(8'h0A);
      checkAll("lat.after");

      pressClear();
`ifdef ALU_LOADER_DEBOUNCE_EN
      // Short glitch must not register as a press
      applyStimulus(8'h07, 1'b1, 1'b0, 10);
      checkAll("glitch");
`endif

      // Held button: exactly one load for a 500-cycle press
      @(negedge clk);
      bus.i_sw       = 8'h06;
      bus.i_btn_load = 1'b1;
      stateChanges   = 0;
      prevState      = bus.o_state;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.o_state !== prevState) stateChanges++;
         prevState = bus.o_state;
      end
      bus.i_btn_load = 1'b0;
      repeat (GAP) @(negedge clk);
      modelLoad(8'h06);
      checkOutput("held.changes", 32'(stateChanges), 32'd1);
      checkAll("held");

      // Randomized loads, clears and simultaneous presses
      for (int i = 0; i < 20; i++) begin
         r  = int'($urandom_range(0, 9));
         sw = 8'($urandom);
         if (r < 7) begin
            pressLoad(sw);
         end else if (r < 9) begin
            pressClear();
         end else begin
            applyStimulus(sw, 1'b1, 1'b1, HOLD);
            modelClear();
         end
         checkAll($sformatf("rand%0d", i));
      end

      // Clear wins over a simultaneous load in S_OP
      pressClear();
      pressLoad(8'h0B);
      pressLoad(8'h04);
      checkOutput("prio.pre", 32'(bus.o_state), 32'd2);
      applyStimulus(8'h3F, 1'b1, 1'b1, HOLD);
      modelClear();
      checkAll("prio");

      // Reload from S_DONE keeps B and code
      pressLoad(8'h07);
      pressLoad(8'h0C);
      pressLoad(8'h15);
      pressLoad(8'h03);
      checkAll("reload");

      // Asynchronous reset mid-cycle with load held through it
      @(negedge clk);
      bus.i_btn_load = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      modelClear();
      #1;
      checkAll("async_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (HOLD + LAT) @(negedge clk);
      checkAll("held_thru_rst");
      bus.i_btn_load = 1'b0;
      repeat (GAP) @(negedge clk);
      pressLoad(8'h09);
      checkAll("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
